// File: rtl/sram_frame_store_pkg.sv
// Shared types and frame constants for the 1-bpp SRAM frame recorder/player.
package sram_frame_store_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } acc_state_e;

    localparam int H_ACTIVE        = 640;
    localparam int V_ACTIVE        = 480;
    localparam int FRAME_BYTES_DEF = H_ACTIVE * V_ACTIVE / 8;

endpackage

// File: rtl/sram_async_port.sv
// Single-access engine for an 8-bit asynchronous SRAM: SETUP, STROBE, HOLD, with
// registered strobes and data-bus drive enable.
module sram_async_port
    import sram_frame_store_pkg::*;
#(
    parameter int ADDR_W        = 18,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              done_write_o,
    output logic [7:0]        rd_data_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [7:0]        sram_dq_out_o,
    output logic              sram_dq_oe_o,
    input  logic [7:0]        sram_dq_in_i,
    output logic              sram_we_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_cs_n_o
);

    localparam logic [1:0] LAST_STROBE = 2'(STROBE_CYCLES - 1);

    acc_state_e        state_q;
    logic [1:0]        strobe_cnt_q;
    logic              write_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        dq_out_q;
    logic              dq_oe_q;
    logic              we_n_q;
    logic              oe_n_q;
    logic              cs_n_q;
    logic [7:0]        rd_data_q;

    // Requests are only taken in IDLE; the parent treats a request while busy as an overrun.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            strobe_cnt_q <= '0;
            write_q      <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= '0;
            dq_out_q     <= '0;
            dq_oe_q      <= 1'b0;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            cs_n_q       <= 1'b1;
            rd_data_q    <= '0;
        end else begin
            cs_n_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        state_q <= ST_SETUP;
                        write_q <= write_i;
                        addr_q  <= addr_i;
                        if (write_i) begin
                            dq_out_q <= data_i;
                            dq_oe_q  <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    state_q      <= ST_STROBE;
                    strobe_cnt_q <= '0;
                    if (write_q) begin
                        we_n_q <= 1'b0;
                    end else begin
                        oe_n_q <= 1'b0;
                    end
                end
                ST_STROBE: begin
                    if (strobe_cnt_q == LAST_STROBE) begin
                        state_q <= ST_HOLD;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        if (!write_q) begin
                            rd_data_q <= sram_dq_in_i;
                        end
                    end else begin
                        strobe_cnt_q <= strobe_cnt_q + 2'd1;
                    end
                end
                ST_HOLD: begin
                    // Write data stays on the bus through HOLD for SRAM data hold time.
                    state_q <= ST_IDLE;
                    dq_oe_q <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign done_write_o  = write_q;
    assign rd_data_o     = rd_data_q;
    assign sram_addr_o   = addr_q;
    assign sram_dq_out_o = dq_out_q;
    assign sram_dq_oe_o  = dq_oe_q;
    assign sram_we_n_o   = we_n_q;
    assign sram_oe_n_o   = oe_n_q;
    assign sram_cs_n_o   = cs_n_q;

endmodule

// File: rtl/sram_frame_store.sv
// 1-bpp frame recorder/player: packs active pixels into SRAM bytes in record mode,
// prefetches and unpacks them into the pixel stream in playback mode.
module sram_frame_store
    import sram_frame_store_pkg::*;
#(
    parameter int ADDR_W        = 18,
    parameter int FRAME_BYTES   = FRAME_BYTES_DEF,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk_x5,
    input  logic              reset,
    input  logic              pix_ce,
    input  logic              frame_start,
    input  logic              active,
    input  logic              rec_n,
    input  logic              pix_in,
    output logic              pix_out,
    output logic              recording,
    output logic              overrun,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_in,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_cs_n
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    logic              rec_meta_q, rec_meta_d;
    logic              rec_sync_q, rec_sync_d;
    logic              recording_q, recording_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              prime_q, prime_d;
    logic              overrun_q, overrun_d;
    logic              pix_out_q, pix_out_d;
    logic [6:0]        wr_sr_q;
    logic [7:0]        rd_sr_q;

    logic              fs_ev, start_play, pix_act, byte_end;
    logic              req, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        wr_byte;
    logic [7:0]        pf_byte;
    logic              port_busy, port_done, port_done_write;

    assign fs_ev      = pix_ce & frame_start;
    assign start_play = fs_ev & rec_sync_q;
    assign pix_act    = pix_ce & active & ~frame_start;
    assign byte_end   = pix_act & (cnt_q == 3'd7);
    assign wr_byte    = {wr_sr_q, pix_in};

    // One requester per cycle; frame_start owns the port on its pixel.
    always_comb begin
        req       = 1'b0;
        req_write = 1'b0;
        req_addr  = wr_ptr_q;
        if (fs_ev) begin
            if (start_play) begin
                req      = 1'b1;
                req_addr = '0;
            end
        end else if (byte_end && recording_q) begin
            req       = 1'b1;
            req_write = 1'b1;
            req_addr  = wr_ptr_q;
        end else if (byte_end) begin
            req      = 1'b1;
            req_addr = rd_ptr_q;
        end else if (port_done && prime_q) begin
            req      = 1'b1;
            req_addr = rd_ptr_q;
        end
    end

    always_comb begin
        rec_meta_d  = rec_n;
        rec_sync_d  = rec_meta_q;
        recording_d = fs_ev ? ~rec_sync_q : recording_q;

        cnt_d = cnt_q;
        if (fs_ev) begin
            cnt_d = '0;
        end else if (pix_act) begin
            cnt_d = cnt_q + 3'd1;
        end

        wr_ptr_d = wr_ptr_q;
        if (fs_ev) begin
            wr_ptr_d = '0;
        end else if (port_done && port_done_write) begin
            wr_ptr_d = next_addr(wr_ptr_q);
        end

        // rd_ptr always names the next byte still to be fetched.
        rd_ptr_d = fs_ev ? '0 : rd_ptr_q;
        if (req && !req_write && !port_busy) begin
            rd_ptr_d = next_addr(req_addr);
        end

        prime_d = prime_q;
        if (fs_ev) begin
            prime_d = start_play;
        end else if (port_done && prime_q) begin
            prime_d = 1'b0;
        end

        overrun_d = overrun_q | (req & port_busy) | (fs_ev & (cnt_q != 3'd0));

        pix_out_d = pix_out_q;
        if (pix_ce) begin
            pix_out_d = recording_q ? pix_in : (pix_act & rd_sr_q[7]);
        end
    end

    always_ff @(posedge clk_x5 or negedge reset) begin
        if (!reset) begin
            rec_meta_q  <= 1'b1;
            rec_sync_q  <= 1'b1;
            recording_q <= 1'b0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            prime_q     <= 1'b0;
            overrun_q   <= 1'b0;
            pix_out_q   <= 1'b0;
        end else begin
            rec_meta_q  <= rec_meta_d;
            rec_sync_q  <= rec_sync_d;
            recording_q <= recording_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            prime_q     <= prime_d;
            overrun_q   <= overrun_d;
            pix_out_q   <= pix_out_d;
        end
    end

    // Pixel shift registers carry data only and need no reset.
    always_ff @(posedge clk_x5) begin
        if (pix_act && recording_q) begin
            wr_sr_q <= {wr_sr_q[5:0], pix_in};
        end
        if (pix_act && !recording_q) begin
            rd_sr_q <= byte_end ? pf_byte : {rd_sr_q[6:0], 1'b0};
        end else if (port_done && prime_q && !fs_ev) begin
            rd_sr_q <= pf_byte;
        end
    end

    sram_async_port #(
        .ADDR_W       (ADDR_W),
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_port (
        .clk_i        (clk_x5),
        .rst_ni       (reset),
        .req_i        (req),
        .write_i      (req_write),
        .addr_i       (req_addr),
        .data_i       (wr_byte),
        .busy_o       (port_busy),
        .done_o       (port_done),
        .done_write_o (port_done_write),
        .rd_data_o    (pf_byte),
        .sram_addr_o  (sram_addr),
        .sram_dq_out_o(sram_dq_out),
        .sram_dq_oe_o (sram_dq_oe),
        .sram_dq_in_i (sram_dq_in),
        .sram_we_n_o  (sram_we_n),
        .sram_oe_n_o  (sram_oe_n),
        .sram_cs_n_o  (sram_cs_n)
    );

    assign pix_out   = pix_out_q;
    assign recording = recording_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sram_frame_store.sv
// Self-checking bench for sram_frame_store with a behavioural SRAM and pixel-stream model.
module tb_sram_frame_store;

    localparam int AW = 18;
    localparam int FB = 24;

    logic          clk_x5 = 1'b0;
    logic          reset, pix_ce, frame_start, active, rec_n, pix_in;
    logic          pix_out, recording, overrun;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_dq_out, sram_dq_in;
    logic          sram_dq_oe, sram_we_n, sram_oe_n, sram_cs_n;

    always #5 clk_x5 = ~clk_x5;

    sram_frame_store #(.ADDR_W(AW), .FRAME_BYTES(FB), .STROBE_CYCLES(2)) dut (
        .clk_x5(clk_x5), .reset(reset), .pix_ce(pix_ce), .frame_start(frame_start),
        .active(active), .rec_n(rec_n), .pix_in(pix_in), .pix_out(pix_out),
        .recording(recording), .overrun(overrun), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_cs_n(sram_cs_n)
    );

    // ---------------- SRAM model and bus monitor ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        int            low;
        logic          oe_hold;
    } wr_t;

    logic [7:0]    mem [0:255];
    wr_t           wr_log[$];
    logic [AW-1:0] rd_log[$];
    logic          we_prev, oe_prev;
    int            we_low;
    logic [AW-1:0] we_addr;
    logic [7:0]    we_data;
    logic          ld_req;
    logic [7:0]    ld_addr, ld_data;

    assign sram_dq_in = sram_oe_n ? 8'h5A : mem[sram_addr[7:0]];

    always @(posedge clk_x5) begin
        if (ld_req) mem[ld_addr] <= ld_data;
        if (!reset) begin
            we_prev <= 1'b1;
            oe_prev <= 1'b1;
            we_low  <= 0;
        end else begin
            we_prev <= sram_we_n;
            oe_prev <= sram_oe_n;
            if (!sram_we_n) begin
                we_low  <= we_low + 1;
                we_addr <= sram_addr;
                we_data <= sram_dq_out;
            end else if (!we_prev) begin
                wr_log.push_back(wr_t'{we_addr, we_data, we_low, sram_dq_oe});
                mem[we_addr[7:0]] <= we_data;
                we_low <= 0;
            end
            if (!sram_oe_n && oe_prev) rd_log.push_back(sram_addr);
        end
    end

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic pixel(input logic act, input logic pin, input logic fs, output logic pout);
        pix_ce = 1'b1; active = act; pix_in = pin; frame_start = fs;
        @(posedge clk_x5); #1;
        pout = pix_out;
        pix_ce = 1'b0; active = 1'b0; frame_start = 1'b0;
        repeat (4) @(posedge clk_x5);
        #1;
    endtask

    task automatic blank();
        logic d;
        pixel(1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        ld_req = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk_x5); #1;
        ld_req = 1'b0;
    endtask

    typedef struct {
        logic rec_n;
        logic fs;
        logic exp_rec;
    } mrow_t;

    mrow_t      mtab[12];
    logic [7:0] ref_mem[FB];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       po, b, exp_b;
        int         base, rbase, nact, k;
        logic [7:0] pat, eb;
        bit         bits[$];

        mtab[0]  = '{1'b1, 1'b0, 1'b0};
        mtab[1]  = '{1'b1, 1'b1, 1'b0};
        mtab[2]  = '{1'b0, 1'b0, 1'b0};
        mtab[3]  = '{1'b0, 1'b0, 1'b0};
        mtab[4]  = '{1'b0, 1'b1, 1'b1};
        mtab[5]  = '{1'b1, 1'b0, 1'b1};
        mtab[6]  = '{1'b1, 1'b0, 1'b1};
        mtab[7]  = '{1'b1, 1'b1, 1'b0};
        mtab[8]  = '{1'b0, 1'b1, 1'b0};
        mtab[9]  = '{1'b0, 1'b1, 1'b1};
        mtab[10] = '{1'b1, 1'b1, 1'b1};
        mtab[11] = '{1'b1, 1'b1, 1'b0};

        reset = 1'b0; pix_ce = 1'b0; frame_start = 1'b0; active = 1'b0;
        rec_n = 1'b1; pix_in = 1'b0; ld_req = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(posedge clk_x5);
        #1;

        // reset values
        chk("rst_pix_out", pix_out, 0);
        chk("rst_recording", recording, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dq_out", sram_dq_out, 0);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_cs_n", sram_cs_n, 1);
        reset = 1'b1;
        @(posedge clk_x5); #1;
        chk("cs_n_after_reset", sram_cs_n, 0);

        // mode latching table
        for (int i = 0; i < 12; i++) begin
            rec_n = mtab[i].rec_n;
            pixel(1'b0, 1'b0, mtab[i].fs, po);
            chk($sformatf("mode_row%0d", i), recording, mtab[i].exp_rec);
        end

        // directed record: 0xB2 then 0x5C
        rec_n = 1'b0;
        blank();
        base = wr_log.size();
        pixel(1'b0, 1'b0, 1'b1, po);
        chk("rec_mode", recording, 1);
        blank(); blank();
        for (int i = 0; i < 16; i++) begin
            pat = (i < 8) ? 8'hB2 : 8'h5C;
            b = pat[7 - (i % 8)];
            pixel(1'b1, b, 1'b0, po);
            if (i % 4 == 0) chk($sformatf("rec_passthru%0d", i), po, b);
        end
        blank(); blank();
        chk("rec_write_count", wr_log.size() - base, 2);
        if (wr_log.size() - base == 2) begin
            chk("w0_addr", wr_log[base].addr, 0);
            chk("w0_data", wr_log[base].data, 8'hB2);
            chk("w0_we_low", wr_log[base].low, 2);
            chk("w0_oe_hold", wr_log[base].oe_hold, 1);
            chk("w1_addr", wr_log[base+1].addr, 1);
            chk("w1_data", wr_log[base+1].data, 8'h5C);
            chk("w1_we_low", wr_log[base+1].low, 2);
        end

        // random record frame with wrap after FB writes
        base = wr_log.size();
        bits.delete();
        pixel(1'b0, 1'b0, 1'b1, po);
        blank(); blank();
        nact = 0;
        while (nact < 8 * (FB + 1)) begin
            b = 1'($urandom_range(1));
            if ($urandom_range(3) == 0) begin
                pixel(1'b0, b, 1'b0, po);
            end else begin
                pixel(1'b1, b, 1'b0, po);
                bits.push_back(b);
                nact++;
            end
            if (po !== b) chk("rand_rec_passthru", po, b);
        end
        blank(); blank();
        chk("wrap_write_count", wr_log.size() - base, FB + 1);
        if (wr_log.size() - base == FB + 1) begin
            for (k = 0; k <= FB; k++) begin
                eb = 8'h00;
                for (int j = 0; j < 8; j++) eb = {eb[6:0], bits[8 * k + j]};
                chk($sformatf("rand_w%0d_addr", k), wr_log[base + k].addr, k % FB);
                chk($sformatf("rand_w%0d_data", k), wr_log[base + k].data, eb);
            end
        end

        // directed playback: 0xB2, 0xFF
        load(8'd0, 8'hB2);
        load(8'd1, 8'hFF);
        rec_n = 1'b1;
        blank();
        rbase = rd_log.size();
        pixel(1'b0, 1'b0, 1'b1, po);
        chk("play_mode", recording, 0);
        blank(); blank();
        for (int i = 0; i < 16; i++) begin
            pat = (i < 8) ? 8'hB2 : 8'hFF;
            exp_b = pat[7 - (i % 8)];
            pixel(1'b1, 1'b0, 1'b0, po);
            chk($sformatf("play_pix%0d", i), po, exp_b);
            if (i == 3) begin
                pixel(1'b0, 1'b1, 1'b0, po);
                chk("play_blank_zero", po, 0);
            end
        end
        blank(); blank();
        chk("play_read_count", (rd_log.size() - rbase >= 3), 1);
        if (rd_log.size() - rbase >= 3) begin
            chk("play_rd0", rd_log[rbase], 0);
            chk("play_rd1", rd_log[rbase+1], 1);
            chk("play_rd2", rd_log[rbase+2], 2);
        end

        // random playback of a full frame
        for (int a = 0; a < FB; a++) begin
            ref_mem[a] = 8'($urandom);
            load(8'(a), ref_mem[a]);
        end
        pixel(1'b0, 1'b0, 1'b1, po);
        blank(); blank();
        nact = 0;
        while (nact < 8 * FB) begin
            if ($urandom_range(3) == 0) begin
                pixel(1'b0, 1'b1, 1'b0, po);
                if (po !== 1'b0) chk("rand_play_blank", po, 0);
            end else begin
                exp_b = ref_mem[nact / 8][7 - (nact % 8)];
                pixel(1'b1, 1'b0, 1'b0, po);
                chk($sformatf("rand_play%0d", nact), po, exp_b);
                nact++;
            end
        end
        blank(); blank();

        // partial byte at frame_start
        chk("no_overrun_yet", overrun, 0);
        rec_n = 1'b0;
        blank();
        pixel(1'b0, 1'b0, 1'b1, po);
        base = wr_log.size();
        for (int i = 0; i < 5; i++) pixel(1'b1, 1'b1, 1'b0, po);
        pixel(1'b0, 1'b0, 1'b1, po);
        chk("partial_overrun", overrun, 1);
        blank(); blank();
        chk("partial_no_write", wr_log.size() - base, 0);
        for (int i = 0; i < 8; i++) begin
            pat = 8'h3C;
            pixel(1'b1, pat[7 - i], 1'b0, po);
        end
        blank(); blank();
        chk("after_partial_count", wr_log.size() - base, 1);
        if (wr_log.size() - base == 1) begin
            chk("after_partial_addr", wr_log[base].addr, 0);
            chk("after_partial_data", wr_log[base].data, 8'h3C);
        end

        // reset during the strobe of a write
        for (int i = 0; i < 7; i++) pixel(1'b1, 1'b0, 1'b0, po);
        pix_ce = 1'b1; active = 1'b1; pix_in = 1'b1;
        @(posedge clk_x5); #1;
        pix_ce = 1'b0; active = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!sram_we_n) break;
            @(posedge clk_x5); #1;
        end
        chk("we_low_seen", sram_we_n, 0);
        chk("oe_during_write", sram_dq_oe, 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_we_n", sram_we_n, 1);
        chk("mid_rst_dq_oe", sram_dq_oe, 0);
        chk("mid_rst_addr", sram_addr, 0);
        chk("mid_rst_dq_out", sram_dq_out, 0);
        chk("mid_rst_cs_n", sram_cs_n, 1);
        chk("mid_rst_recording", recording, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_pix_out", pix_out, 0);
        repeat (3) @(posedge clk_x5);
        #1 reset = 1'b1;
        rec_n = 1'b1;
        repeat (3) @(posedge clk_x5);
        #1;

        // second request while the port is busy
        blank();
        chk("pre_busy_overrun", overrun, 0);
        pix_ce = 1'b1; frame_start = 1'b1;
        @(posedge clk_x5); #1;
        chk("first_fs_no_overrun", overrun, 0);
        @(posedge clk_x5); #1;
        pix_ce = 1'b0; frame_start = 1'b0;
        repeat (6) @(posedge clk_x5);
        #1;
        chk("busy_overrun", overrun, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
